// File: rtl/rv32i_data_mem_responder.sv
// rv32i_data_mem_responder
// Memory-side responder for the RV32I data-memory request interface.
// Writes land in one cycle with per-byte enables; reads return after a
// fixed READ_LAT-cycle latency with a busy/valid handshake. Out-of-range
// and malformed (read+write) requests raise a one-cycle memErr pulse.
//
// Optional feature: define RV32I_DMEM_ZEROIZE_EN to sweep the array to
// zero (one word per cycle, memBusy held high) after every reset release.
// Without it the array is not initialised and reads of unwritten words
// return whatever the storage holds.
module rv32i_data_mem_responder #(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWData,
  input  logic [3:0]  memWMask,
  input  logic        memRStrb,
  output logic [31:0] memRData,
  output logic        memRValid,
  output logic        memBusy,
  output logic        memErr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;
`ifdef RV32I_DMEM_ZEROIZE_EN
  localparam logic [1:0] CLEAR   = 2'd3;
`endif

  logic [1:0]    state;
  logic [2:0]    lat_cnt;
  logic [31:0]   cap_data;
  logic          cap_oor;
  logic [31:0]   mem [DEPTH];
`ifdef RV32I_DMEM_ZEROIZE_EN
  logic [AW-1:0] clr_idx;
`endif

  logic [29:0]   word_idx;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          can_accept;
  logic          wr_req;
  logic          rd_req;
  logic          bad_req;
  logic          wr_en;
  logic [31:0]   rd_word;
  logic          unused_addr_lsb;

  // Byte offset within the word has no effect on any access.
  assign unused_addr_lsb = ^memAddr[1:0];

  // Decode and classify the request presented this cycle.
  always_comb begin
    word_idx   = memAddr[31:2];
    idx        = memAddr[AW+1:2];
    in_range   = (word_idx < 30'(DEPTH));
    // Requests are sampled only when not busy; RESP still accepts so
    // reads can run back to back. Nothing is accepted under reset.
    can_accept = ((state == IDLE) || (state == RESP)) && !rst;
    wr_req     = can_accept && (memWMask != 4'b0000) && !memRStrb;
    rd_req     = can_accept && memRStrb && (memWMask == 4'b0000);
    bad_req    = can_accept && memRStrb && (memWMask != 4'b0000);
    wr_en      = wr_req && in_range;
    // Out-of-range reads complete normally but return zero.
    rd_word    = in_range ? mem[idx] : 32'h0000_0000;
  end

  // Busy covers the read wait (and the zeroize sweep, including reset).
  always_comb begin
`ifdef RV32I_DMEM_ZEROIZE_EN
    memBusy = rst || (state == RD_WAIT) || (state == CLEAR);
`else
    memBusy = (state == RD_WAIT);
`endif
  end

  // Storage: byte-masked writes, plus the zeroize sweep when enabled.
  always_ff @(posedge clk) begin
`ifdef RV32I_DMEM_ZEROIZE_EN
    if (state == CLEAR) begin
      mem[clr_idx] <= 32'h0000_0000;
    end else
`endif
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (memWMask[i]) begin
          mem[idx][8*i +: 8] <= memWData[8*i +: 8];
        end
      end
    end
  end

  // Read capture: the word is sampled at acceptance and held until RESP.
  always_ff @(posedge clk) begin
    if (rd_req) begin
      cap_data <= rd_word;
      cap_oor  <= !in_range;
    end
  end

  // Control FSM: acceptance, latency countdown, response and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef RV32I_DMEM_ZEROIZE_EN
      state   <= CLEAR;
      clr_idx <= '0;
`else
      state   <= IDLE;
`endif
      lat_cnt   <= 3'd0;
      memRData  <= 32'h0000_0000;
      memRValid <= 1'b0;
      memErr    <= 1'b0;
    end else begin
      memRValid <= 1'b0;
      memErr    <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (rd_req) begin
            if (READ_LAT == 1) begin
              // Single-cycle latency: respond straight away, never busy.
              state     <= RESP;
              memRValid <= 1'b1;
              memRData  <= rd_word;
              memErr    <= !in_range;
            end else begin
              state   <= RD_WAIT;
              lat_cnt <= LAT_INIT;
            end
          end else begin
            state <= IDLE;
            if (bad_req || (wr_req && !in_range)) begin
              memErr <= 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt <= 3'd1) begin
            state     <= RESP;
            lat_cnt   <= 3'd0;
            memRValid <= 1'b1;
            memRData  <= cap_data;
            memErr    <= cap_oor;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
`ifdef RV32I_DMEM_ZEROIZE_EN
        CLEAR: begin
          if (clr_idx == AW'(DEPTH - 1)) begin
            state <= IDLE;
          end
          clr_idx <= clr_idx + 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rv32i_data_mem_responder.md
Name: rv32i_data_mem_responder

Overview:
- Memory-side responder for the RV32I core's data-memory request interface: memAddr, memWData, memWMask, memRStrb in; memRData out.
- Services byte-masked writes in one cycle.
- Services word reads after a fixed, parameterised latency, with a busy/valid handshake back to the core.
- Backed by an internal word array; flags out-of-range and malformed requests.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, 16..65536.
- READ_LAT, 2, cycles from read acceptance to memRValid; legal range 1..4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- memAddr  in  32  byte address; word index = memAddr[31:2], bits [1:0] ignored.
- memWData  in  32  write data; byte lane i = bits [8i+7:8i].
- memWMask  in  4  byte write enables; nonzero means write request.
- memRStrb  in  1  read request.
- memRData  out  32  read data; valid while memRValid=1, holds value otherwise.
- memRValid  out  1  one-cycle pulse when a read completes.
- memBusy  out  1  high while a read is outstanding; requests are ignored while high.
- memErr  out  1  one-cycle pulse flagging a rejected request.

Behaviour:
- Reset (async, active-high): memRData=0, memRValid=0, memBusy=0, memErr=0, FSM=IDLE, latency counter=0. Array contents untouched (see optional feature).
- Reset asserted mid-read drops the pending read; no memRValid is produced for it.
- Acceptance: a request is sampled at a rising edge only when memBusy=0.
  - Requests seen while memBusy=1 are ignored, not queued; the initiator must hold them.
- Classification at the acceptance edge:
  - Write: memWMask!=0 and memRStrb=0.
  - Read: memRStrb=1 and memWMask=0.
  - Both asserted: illegal. memErr pulses in the next cycle; no array access, no memRValid.
  - Neither asserted: no operation.
- Range check: word index >= DEPTH is out-of-range.
  - Write: dropped, memErr pulses next cycle.
  - Read: completes normally with memRData=0 and memErr pulsing in the same cycle as memRValid.
- Write:
  - Lane i is written iff memWMask[i]=1; other lanes are preserved.
  - Completes at the acceptance edge; memBusy stays 0.
  - Visible to a read accepted at the next edge (no write-to-read hazard).
- Read FSM states:
  - IDLE: on a legal read at edge E0, capture the array word and go to RD_WAIT with counter=READ_LAT-1.
    - If READ_LAT=1, skip RD_WAIT: memRValid=1 and memRData valid in the cycle after E0; memBusy never rises.
  - RD_WAIT: memBusy=1, counter decrements each edge. When counter reaches 0, go to RESP.
  - RESP: memRValid=1, memBusy=0, memRData=captured word.
    - A new request may be accepted at the edge ending RESP (back-to-back reads).
    - Otherwise return to IDLE.
- Timing summary: memRValid is high exactly READ_LAT cycles after the acceptance edge. memBusy is high for READ_LAT-1 cycles.
- Output rules:
  - memRData updates only on read completion; it holds the last value otherwise.
  - memRValid and memErr are single-cycle pulses, never held.
- Address wrap: none; word index >= DEPTH is always an error, never aliased.

Optional Feature:
- Macro: RV32I_DMEM_ZEROIZE_EN.
- Defined: on reset deassertion the FSM enters CLEAR.
  - Writes 0 to one word per cycle, indices 0..DEPTH-1.
  - memBusy=1 throughout; requests are ignored.
  - Returns to IDLE after DEPTH cycles.
  - Reset during CLEAR restarts the clear from index 0.
  - memBusy is 1 while rst is asserted.
- Not defined: no CLEAR state. memBusy resets to 0 and array contents are undefined (X in simulation) until written.

Test Plan:
- Write 0xDEADBEEF to 0x10 with mask 4'b1111, then read 0x10 (READ_LAT=2) -> memBusy high 1 cycle; memRValid pulses 2 cycles after acceptance with memRData=0xDEADBEEF.
- Partial write: write 0x11223344 to 0x20 with mask 1111, then 0xAABBCCDD with mask 0101, then read -> memRData=0x11BB33DD.
- Back-to-back reads of 0x0 and 0x4, second held during busy -> two memRValid pulses READ_LAT cycles apart; the second request is not lost.
- Read at word index DEPTH (byte 0x1000, DEPTH=1024) -> memRValid and memErr pulse together, memRData=0. A write to the same address -> memErr pulse only; a read of 0x0 afterwards is unchanged.
- memRStrb=1 with memWMask=4'b0011 -> memErr pulses next cycle; no memRValid; array unchanged.
- Assert rst during RD_WAIT -> memRValid never pulses and all outputs are 0. With RV32I_DMEM_ZEROIZE_EN and DEPTH=16: memBusy high 16 cycles after reset release, then any read returns 0.
